// File: rtl/avalon_blit_queue.sv
// avalon_blit_queue
//   Avalon-MM command front end for the blitter. Software stages an object
//   index and bounding box, then pushes it into a command FIFO. An issue FSM
//   hands one command at a time to the blitter and waits for ENG_DONE.
//
// Ports
//   CLK, RESET_N                      clock, asynchronous active-low reset
//   AVL_CS/READ/WRITE/ADDR/WRITEDATA  Avalon-MM slave strobes, 8 word registers
//   AVL_READDATA                      registered read data, latency 1, 0 when idle
//   CMD_VALID / CMD_READY             command handshake to the blitter
//   CMD_IDX, CMD_X0..CMD_Y1, CMD_TRANS  issued command (clamped inclusive box)
//   ENG_DONE                          completion pulse for the accepted command
//   FRAME_DONE                        CTRL[0]
//   IRQ                               irq_pending & irq_en
module avalon_blit_queue #(
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned COORD_W  = 11,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               AVL_READ,
    input  logic               AVL_WRITE,
    input  logic               AVL_CS,
    input  logic [2:0]         AVL_ADDR,
    input  logic [31:0]        AVL_WRITEDATA,
    output logic [31:0]        AVL_READDATA,
    output logic               CMD_VALID,
    input  logic               CMD_READY,
    output logic [IDX_W-1:0]   CMD_IDX,
    output logic [COORD_W-1:0] CMD_X0,
    output logic [COORD_W-1:0] CMD_Y0,
    output logic [COORD_W-1:0] CMD_X1,
    output logic [COORD_W-1:0] CMD_Y1,
    output logic               CMD_TRANS,
    input  logic               ENG_DONE,
    output logic               FRAME_DONE,
    output logic               IRQ
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = 1 + IDX_W + 4 * COORD_W;
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);
    localparam logic [AW:0]        LVL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]   idx_r;
    logic [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r;
    logic               frame_done, irq_en, trans_r;
    logic               irq_pending, overflow, bad_box;
    logic [7:0]         done_count;

    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic [AW:0]        level;
    logic [EW-1:0]      cmd_q;

    logic               wr, rd, flush, push_req, push_ok, pop, eng_fin;
    logic               empty, full, busy, box_bad;
    logic [COORD_W-1:0] x1_c, y1_c;
    logic [31:0]        rd_mux;
    logic               unused_ok;

    assign unused_ok = ^AVL_WRITEDATA;

    assign wr       = AVL_CS & AVL_WRITE;
    assign rd       = AVL_CS & AVL_READ;
    assign flush    = wr && (AVL_ADDR == 3'd5) && AVL_WRITEDATA[3];
    assign push_req = wr && (AVL_ADDR == 3'd6);

    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);
    assign busy  = (state != S_IDLE);

    assign x1_c    = (x1_r > X_MAX) ? X_MAX : x1_r;
    assign y1_c    = (y1_r > Y_MAX) ? Y_MAX : y1_r;
    assign box_bad = (x0_r > x1_c) || (y0_r > y1_c);

    // Flush discards a same-cycle push; fullness is judged before any pop.
    assign push_ok = push_req && !flush && !box_bad && !full;
    assign eng_fin = (state == S_WAIT) && ENG_DONE;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: if (CMD_READY) state_next = S_WAIT;
            S_WAIT:  if (ENG_DONE)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wptr] <= {trans_r, idx_r, x0_r, y0_r, x1_c, y1_c};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            cmd_q <= '0;
        end else begin
            if (pop) cmd_q <= mem[rptr];
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (push_ok) wptr <= wptr + 1'b1;
                if (pop)     rptr <= rptr + 1'b1;
                if (push_ok && !pop)      level <= level + 1'b1;
                else if (!push_ok && pop) level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            idx_r       <= '0;
            x0_r        <= '0;
            y0_r        <= '0;
            x1_r        <= '0;
            y1_r        <= '0;
            frame_done  <= 1'b0;
            irq_en      <= 1'b0;
            trans_r     <= 1'b0;
            irq_pending <= 1'b0;
            overflow    <= 1'b0;
            bad_box     <= 1'b0;
            done_count  <= '0;
        end else begin
            if (wr) begin
                case (AVL_ADDR)
                    3'd0: idx_r <= AVL_WRITEDATA[IDX_W-1:0];
                    3'd1: x0_r  <= AVL_WRITEDATA[COORD_W-1:0];
                    3'd2: y0_r  <= AVL_WRITEDATA[COORD_W-1:0];
                    3'd3: x1_r  <= AVL_WRITEDATA[COORD_W-1:0];
                    3'd4: y1_r  <= AVL_WRITEDATA[COORD_W-1:0];
                    3'd5: begin
                        frame_done <= AVL_WRITEDATA[0];
                        irq_en     <= AVL_WRITEDATA[1];
                        trans_r    <= AVL_WRITEDATA[2];
                    end
                    3'd7: begin
                        if (AVL_WRITEDATA[3]) irq_pending <= 1'b0;
                        if (AVL_WRITEDATA[4]) overflow    <= 1'b0;
                        if (AVL_WRITEDATA[5]) bad_box     <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // Hardware set events take priority over a same-cycle W1C.
            if (push_req && !flush && box_bad)          bad_box  <= 1'b1;
            if (push_req && !flush && !box_bad && full) overflow <= 1'b1;
            if (eng_fin) begin
                done_count <= done_count + 8'd1;
                if (empty && irq_en) irq_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (AVL_ADDR)
            3'd0: rd_mux[IDX_W-1:0]   = idx_r;
            3'd1: rd_mux[COORD_W-1:0] = x0_r;
            3'd2: rd_mux[COORD_W-1:0] = y0_r;
            3'd3: rd_mux[COORD_W-1:0] = x1_r;
            3'd4: rd_mux[COORD_W-1:0] = y1_r;
            3'd5: rd_mux[2:0]         = {trans_r, irq_en, frame_done};
            3'd6: rd_mux[AW:0]        = level;
            3'd7: rd_mux[15:0]        = {done_count, 2'b00, bad_box, overflow,
                                         irq_pending, busy, full, empty};
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) AVL_READDATA <= '0;
        else          AVL_READDATA <= rd ? rd_mux : '0;
    end

    assign {CMD_TRANS, CMD_IDX, CMD_X0, CMD_Y0, CMD_X1, CMD_Y1} = cmd_q;
    assign CMD_VALID  = (state == S_ISSUE);
    assign FRAME_DONE = frame_done;
    assign IRQ        = irq_pending & irq_en;

endmodule

// File: tb/tb_avalon_blit_queue.sv
// Self-checking bench for avalon_blit_queue: accepted pushes enqueue the
// expected command into a scoreboard, a negedge monitor compares every
// CMD_VALID/CMD_READY handshake against it; register reads are checked inline.
module tb_avalon_blit_queue;

    localparam int unsigned IDX_W   = 10;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned DEPTH   = 8;

    typedef struct packed {
        logic               trans;
        logic [IDX_W-1:0]   idx;
        logic [COORD_W-1:0] x0, y0, x1, y1;
    } cmd_t;

    logic               CLK = 1'b0;
    logic               RESET_N;
    logic               AVL_READ, AVL_WRITE, AVL_CS;
    logic [2:0]         AVL_ADDR;
    logic [31:0]        AVL_WRITEDATA;
    logic [31:0]        AVL_READDATA;
    logic               CMD_VALID, CMD_READY;
    logic [IDX_W-1:0]   CMD_IDX;
    logic [COORD_W-1:0] CMD_X0, CMD_Y0, CMD_X1, CMD_Y1;
    logic               CMD_TRANS, ENG_DONE, FRAME_DONE, IRQ;

    int   checks = 0;
    int   errors = 0;
    cmd_t exp_q[$];

    avalon_blit_queue #(
        .IDX_W(IDX_W), .COORD_W(COORD_W), .DEPTH(DEPTH),
        .SCREEN_W(640), .SCREEN_H(480)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_IDX(CMD_IDX), .CMD_X0(CMD_X0), .CMD_Y0(CMD_Y0),
        .CMD_X1(CMD_X1), .CMD_Y1(CMD_Y1), .CMD_TRANS(CMD_TRANS),
        .ENG_DONE(ENG_DONE), .FRAME_DONE(FRAME_DONE), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        cmd_t e, a;
        if (RESET_N === 1'b1 && CMD_VALID === 1'b1 && CMD_READY === 1'b1) begin
            a = {CMD_TRANS, CMD_IDX, CMD_X0, CMD_Y0, CMD_X1, CMD_Y1};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got idx=%0d with no command expected", CMD_IDX);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("cmd idx=%0d (%0d,%0d)-(%0d,%0d) t=%0d",
                      e.idx, e.x0, e.y0, e.x1, e.y1, e.trans), 64'(a), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = addr; AVL_WRITEDATA = data;
        tick();
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_WRITEDATA = '0;
    endtask

    task automatic bus_read(input string name, input logic [2:0] addr, input logic [31:0] exp);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = addr;
        tick();
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        check(name, 64'(AVL_READDATA), 64'(exp));
    endtask

    task automatic stage_push(input int idx, input int x0, input int y0, input int x1, input int y1,
                              input bit accept, input bit tr, input int ex1, input int ey1);
        cmd_t e;
        bus_write(3'd0, 32'(idx));
        bus_write(3'd1, 32'(x0));
        bus_write(3'd2, 32'(y0));
        bus_write(3'd3, 32'(x1));
        bus_write(3'd4, 32'(y1));
        if (accept) begin
            e.trans = tr;
            e.idx   = IDX_W'(idx);
            e.x0    = COORD_W'(x0);
            e.y0    = COORD_W'(y0);
            e.x1    = COORD_W'(ex1);
            e.y1    = COORD_W'(ey1);
            exp_q.push_back(e);
        end
        bus_write(3'd6, 32'h0);
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (CMD_VALID !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ok = (CMD_VALID === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid_timeout: got CMD_VALID=%0b expected 1 within 20 cycles", CMD_VALID);
        end
    endtask

    task automatic complete_one();
        bit ok;
        wait_valid(ok);
        if (ok) begin
            CMD_READY = 1'b1;
            tick();
            CMD_READY = 1'b0;
            ENG_DONE  = 1'b1;
            tick();
            ENG_DONE  = 1'b0;
        end
    endtask

    initial begin
        cmd_t snap;
        bit   ok;
        bit   seen;

        RESET_N = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
        AVL_ADDR = '0; AVL_WRITEDATA = '0; CMD_READY = 1'b0; ENG_DONE = 1'b0;
        repeat (3) tick();
        check("rst_cmd_valid", 64'(CMD_VALID), 64'd0);
        check("rst_irq", 64'(IRQ), 64'd0);
        check("rst_frame_done", 64'(FRAME_DONE), 64'd0);
        check("rst_readdata", 64'(AVL_READDATA), 64'd0);
        RESET_N = 1'b1;
        tick();
        bus_read("rst_status", 3'd7, 32'h0001);
        tick();
        check("readdata_idle_zero", 64'(AVL_READDATA), 64'd0);
        ENG_DONE = 1'b1; tick(); ENG_DONE = 1'b0;
        bus_read("eng_done_ignored_idle", 3'd7, 32'h0001);

        // Single command
        bus_write(3'd0, 32'd5);
        bus_write(3'd1, 32'd10);
        bus_write(3'd2, 32'd20);
        bus_write(3'd3, 32'd49);
        bus_write(3'd4, 32'd59);
        bus_read("x1_readback", 3'd3, 32'd49);
        bus_read("y0_readback", 3'd2, 32'd20);
        exp_q.push_back('{trans: 1'b0, idx: 10'd5, x0: 11'd10, y0: 11'd20, x1: 11'd49, y1: 11'd59});
        bus_write(3'd6, 32'h0);
        check("valid_not_yet", 64'(CMD_VALID), 64'd0);
        tick();
        check("valid_after_2", 64'(CMD_VALID), 64'd1);
        snap = {CMD_TRANS, CMD_IDX, CMD_X0, CMD_Y0, CMD_X1, CMD_Y1};
        check("single_fields", 64'(snap), 64'({1'b0, 10'd5, 11'd10, 11'd20, 11'd49, 11'd59}));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_stable", 64'({CMD_VALID, CMD_TRANS, CMD_IDX, CMD_X0, CMD_Y0, CMD_X1, CMD_Y1}),
                  64'({1'b1, snap}));
        end
        CMD_READY = 1'b1; tick(); CMD_READY = 1'b0;
        bus_read("status_wait_busy", 3'd7, 32'h0005);
        ENG_DONE = 1'b1; tick(); ENG_DONE = 1'b0;
        bus_read("status_single_done", 3'd7, 32'h0101);

        // Clamp with trans captured, then reject
        bus_write(3'd5, 32'h4);
        bus_read("ctrl_trans", 3'd5, 32'h4);
        stage_push(7, 600, 400, 700, 500, 1'b1, 1'b1, 639, 479);
        bus_write(3'd5, 32'h0);
        complete_one();
        stage_push(9, 50, 0, 40, 10, 1'b0, 1'b0, 0, 0);
        bus_read("status_bad_box", 3'd7, 32'h0221);
        bus_read("level_after_reject", 3'd6, 32'd0);
        bus_write(3'd7, 32'h20);
        bus_read("bad_box_cleared", 3'd7, 32'h0201);

        // Fill and overflow
        for (int i = 0; i <= DEPTH; i++)
            stage_push(16 + i, i, i, i + 10, i + 10, 1'b1, 1'b0, i + 10, i + 10);
        bus_read("level_full", 3'd6, 32'(DEPTH));
        bus_read("status_full", 3'd7, 32'h0206);
        stage_push(99, 1, 1, 2, 2, 1'b0, 1'b0, 0, 0);
        bus_read("status_overflow", 3'd7, 32'h0216);
        bus_write(3'd7, 32'h10);
        bus_read("overflow_cleared", 3'd7, 32'h0206);
        for (int i = 0; i <= DEPTH; i++) complete_one();
        bus_read("status_drained", 3'd7, 32'h0B01);

        // Interrupt after the last of three
        bus_write(3'd5, 32'h2);
        stage_push(100, 0, 0, 1, 1, 1'b1, 1'b0, 1, 1);
        stage_push(101, 2, 2, 3, 3, 1'b1, 1'b0, 3, 3);
        stage_push(102, 4, 4, 5, 5, 1'b1, 1'b0, 5, 5);
        complete_one();
        check("irq_after_1", 64'(IRQ), 64'd0);
        complete_one();
        check("irq_after_2", 64'(IRQ), 64'd0);
        complete_one();
        check("irq_after_3", 64'(IRQ), 64'd1);
        bus_read("status_irq", 3'd7, 32'h0E09);
        bus_write(3'd7, 32'h08);
        check("irq_cleared", 64'(IRQ), 64'd0);
        bus_read("status_irq_cleared", 3'd7, 32'h0E01);
        bus_write(3'd5, 32'h3);
        check("frame_done_set", 64'(FRAME_DONE), 64'd1);
        bus_read("ctrl_readback", 3'd5, 32'h3);
        bus_write(3'd5, 32'h0);
        check("frame_done_clr", 64'(FRAME_DONE), 64'd0);

        // Flush with one command in WAIT
        stage_push(200, 10, 10, 20, 20, 1'b1, 1'b0, 20, 20);
        wait_valid(ok);
        CMD_READY = 1'b1; tick(); CMD_READY = 1'b0;
        for (int i = 0; i < 4; i++)
            stage_push(201 + i, 1, 1, 9, 9, 1'b0, 1'b0, 0, 0);
        bus_read("level_before_flush", 3'd6, 32'd4);
        bus_write(3'd5, 32'h8);
        bus_read("level_after_flush", 3'd6, 32'd0);
        ENG_DONE = 1'b1; tick(); ENG_DONE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (CMD_VALID === 1'b1) seen = 1'b1;
            tick();
        end
        check("no_issue_after_flush", 64'(seen), 64'd0);
        bus_read("status_after_flush", 3'd7, 32'h0F01);

        // Async reset mid-ISSUE
        stage_push(300, 5, 5, 6, 6, 1'b1, 1'b0, 6, 6);
        wait_valid(ok);
        exp_q.delete();
        #2 RESET_N = 1'b0;
        #1;
        check("async_valid_low", 64'(CMD_VALID), 64'd0);
        check("async_idx_zero", 64'(CMD_IDX), 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        bus_read("status_after_reset", 3'd7, 32'h0001);
        bus_read("level_after_reset", 3'd6, 32'd0);
        bus_read("idx_after_reset", 3'd0, 32'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
